key_input_conditioner: RTL and testbench



---
 rtl/key_input_conditioner.sv | 121 ++++++++++++
 tb/tb_key_input_conditioner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// key_input_conditioner
// Conditions raw board KEY/SW inputs for the HEX scroll counter. Each channel
// gets a two-flop synchronizer, a debounce counter, a normalized active-high
// level, single-cycle press/release pulses and a press-toggled latch.
// Channels are fully independent and share only the clock and reset.

module key_input_conditioner #(
    parameter int NUM_IN          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_IN-1:0] raw_in,
    output logic [NUM_IN-1:0] level_out,
    output logic [NUM_IN-1:0] press_pulse,
    output logic [NUM_IN-1:0] release_pulse,
    output logic [NUM_IN-1:0] toggle_out
);

    // Terminal count: a new level is accepted when the counter sits here while
    // the synchronized input still differs from the current level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Inversion mask so that the synchronizer always sees 1 = asserted and
    // its inactive (reset) value is 0 for both KEY and SW style inputs.
    localparam logic [NUM_IN-1:0] INV_MASK = ACTIVE_LOW ? {NUM_IN{1'b1}} : {NUM_IN{1'b0}};

    logic [NUM_IN-1:0] norm_in;

    logic [NUM_IN-1:0] sync1_q;
    logic [NUM_IN-1:0] sync2_q;

    logic [CNT_W-1:0]  cnt_q [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];

    logic [NUM_IN-1:0] level_q;
    logic [NUM_IN-1:0] level_d;

    logic [NUM_IN-1:0] press_q;
    logic [NUM_IN-1:0] press_d;
    logic [NUM_IN-1:0] release_q;
    logic [NUM_IN-1:0] release_d;

    logic [NUM_IN-1:0] toggle_q;
    logic [NUM_IN-1:0] toggle_d;

    assign norm_in = raw_in ^ INV_MASK;

    // Two-flop synchronizer; nothing sits between the two stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= norm_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles where the synchronized input differs
    // from the accepted level; any agreement restarts the run from zero.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Edge pulses are derived from the next level so they line up with the
    // cycle in which level_out takes its new value. The toggle flips one
    // cycle later, on the edge that sees press_pulse high.
    always_comb begin
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        toggle_d  = toggle_q ^ press_q;
    end

    // Debounce counters and accepted level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
        end
    end

    // Registered press/release pulses and the press-toggled latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign toggle_out    = toggle_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with NUM_IN=2, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1. Inputs are driven 1 time unit after a rising edge and outputs
// are sampled 1 time unit after the following rising edge.

module tb_key_input_conditioner;

    localparam int NUM_IN = 2;
    localparam int DEB    = 4;
    localparam int CW     = 3;

    logic              clk;
    logic              rst;
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] lvl;
    logic [NUM_IN-1:0] prs;
    logic [NUM_IN-1:0] rel;
    logic [NUM_IN-1:0] tog;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] raw;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] tog;
    } vec_t;

    vec_t vecs[$];

    key_input_conditioner #(
        .NUM_IN(NUM_IN),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clk),
        .reset(rst),
        .raw_in(raw),
        .level_out(lvl),
        .press_pulse(prs),
        .release_pulse(rel),
        .toggle_out(tog)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] e_lvl,
                           input logic [1:0] e_prs, input logic [1:0] e_rel, input logic [1:0] e_tog);
        chk({tag, ".level"}, idx, lvl, e_lvl);
        chk({tag, ".press"}, idx, prs, e_prs);
        chk({tag, ".release"}, idx, rel, e_rel);
        chk({tag, ".toggle"}, idx, tog, e_tog);
    endtask

    task automatic rep(input int n, input logic [1:0] r, input logic [1:0] l,
                       input logic [1:0] p, input logic [1:0] q, input logic [1:0] t);
        vec_t v;
        v.raw = r; v.lvl = l; v.prs = p; v.rel = q; v.tog = t;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Bounce on channel 0: low for 3 cycles only, nothing may change.
        rep(3, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        rep(5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        // Press channel 0: level rises on the 6th edge, toggle one edge later.
        rep(5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        rep(1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
        rep(2, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
        // Release channel 0: release pulse on the 6th edge, toggle holds.
        rep(5, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01);
        rep(1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01);
        rep(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01);
        // Second press/release returns toggle to 0.
        rep(5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
        rep(1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01);
        rep(2, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        rep(5, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
        rep(1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
        rep(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        // Both channels pressed together, then released together.
        rep(5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rep(1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
        rep(2, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        rep(5, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
        rep(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11);
        rep(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);

        // Reset held with inputs inactive.
        rst = 1'b1;
        raw = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;

        // Idle after reset release: everything stays 0 for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("idle", i, 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Table-driven sequences.
        for (int i = 0; i < vecs.size(); i++) begin
            raw = vecs[i].raw;
            step();
            chk_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].tog);
        end

        // Reset in the middle of a debounce run on channel 0 (toggle is 11 here).
        raw = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("pre_rst", i, 2'b00, 2'b00, 2'b00, 2'b11);
        end
        #1;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_all("post_rst", i, (i == 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        step();
        chk_all("post_rst", 7, 2'b01, 2'b00, 2'b00, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
